// File: rtl/tile_redraw_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// tile_redraw_scheduler_pkg : shared tile geometry, graphic ids and FSM states
// Rev 1.0
// ============================================================================
package tile_redraw_scheduler_pkg;

    localparam int REL_BITS         = 4;
    localparam int PIXELS_WIDTH     = 16;
    localparam int PIXEL_COLOR_BITS = 8;
    localparam int GFX_ID_BITS      = 3;

    localparam logic [GFX_ID_BITS-1:0] GFX_EMPTY_BOX = 3'd0;
    localparam logic [GFX_ID_BITS-1:0] GFX_WALL      = 3'd1;
    localparam logic [GFX_ID_BITS-1:0] GFX_PELLET    = 3'd2;
    localparam logic [GFX_ID_BITS-1:0] GFX_POWER     = 3'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BLIT = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tile_redraw_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// tile_redraw_scheduler_rr_arbiter : round-robin priority select from i_ptr up
// Rev 1.0
// ============================================================================
module tile_redraw_scheduler_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [PTR_W-1:0]   o_idx,
    output logic               o_any
);

    int               w_cand;
    logic [PTR_W-1:0] w_sel;

    // Scan from farthest to nearest so the closest requester at/after i_ptr wins.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_cand  = 0;
        w_sel   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_cand = int'(i_ptr) + k;
            if (w_cand >= NUM_REQ) begin
                w_cand = w_cand - NUM_REQ;
            end
            w_sel = PTR_W'(w_cand);
            if (i_req[w_sel]) begin
                o_grant        = '0;
                o_grant[w_sel] = 1'b1;
                o_idx          = w_sel;
                o_any          = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tile_redraw_scheduler.sv
`default_nettype none
// ============================================================================
// tile_redraw_scheduler : arbitrates tile redraws and streams ROM pixels to FB
// Rev 1.0
// ============================================================================
module tile_redraw_scheduler
    import tile_redraw_scheduler_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int TILE_COL_BITS = 5,
    parameter int TILE_ROW_BITS = 5,
    parameter int GFX_BITS      = GFX_ID_BITS
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_REQ-1:0]                i_req_valid,
    input  logic [NUM_REQ*TILE_COL_BITS-1:0]  i_req_col,
    input  logic [NUM_REQ*TILE_ROW_BITS-1:0]  i_req_row,
    input  logic [NUM_REQ*GFX_BITS-1:0]       i_req_gfx,
    output logic [NUM_REQ-1:0]                o_req_ready,
    output logic [GFX_BITS-1:0]               o_gfx_sel,
    output logic [REL_BITS-1:0]               o_rel_x,
    output logic [REL_BITS-1:0]               o_rel_y,
    input  logic [PIXEL_COLOR_BITS-1:0]       i_gfx_pixels,
    output logic                              o_fb_wr_valid,
    input  logic                              i_fb_wr_ready,
    output logic [TILE_COL_BITS+REL_BITS-1:0] o_fb_x,
    output logic [TILE_ROW_BITS+REL_BITS-1:0] o_fb_y,
    output logic [PIXEL_COLOR_BITS-1:0]       o_fb_color,
    output logic                              o_busy,
    output logic                              o_done
);

    localparam int                  c_PTR_W    = ptr_width(NUM_REQ);
    localparam logic [REL_BITS-1:0] c_REL_LAST = REL_BITS'(PIXELS_WIDTH - 1);

    state_t                            r_state;
    state_t                            w_next_state;
    logic [c_PTR_W-1:0]                r_rr_ptr;
    logic [TILE_COL_BITS-1:0]          r_col;
    logic [TILE_ROW_BITS-1:0]          r_row;
    logic [GFX_BITS-1:0]               r_gfx;
    logic [REL_BITS-1:0]               r_rel_x;
    logic [REL_BITS-1:0]               r_rel_y;
    logic                              r_addr_left;
    logic                              r_fb_valid;
    logic [TILE_COL_BITS+REL_BITS-1:0] r_fb_x;
    logic [TILE_ROW_BITS+REL_BITS-1:0] r_fb_y;
    logic [PIXEL_COLOR_BITS-1:0]       r_fb_color;

    logic [NUM_REQ-1:0]                w_grant;
    logic [c_PTR_W-1:0]                w_grant_idx;
    logic                              w_grant_any;
    logic                              w_take;
    logic                              w_load;
    logic                              w_accept;
    logic                              w_last_addr;

    tile_redraw_scheduler_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (c_PTR_W)
    ) u_rr_arbiter (
        .i_req   (i_req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_grant_idx),
        .o_any   (w_grant_any)
    );

    assign w_accept    = r_fb_valid && i_fb_wr_ready;
    assign w_last_addr = (r_rel_x == c_REL_LAST) && (r_rel_y == c_REL_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_take       = 1'b0;
        w_load       = 1'b0;
        o_req_ready  = '0;
        case (r_state)
            IDLE: begin
                if (w_grant_any) begin
                    w_take       = 1'b1;
                    o_req_ready  = w_grant;
                    w_next_state = BLIT;
                end
            end
            BLIT: begin
                // The output register refills whenever it is empty or draining this cycle.
                w_load = r_addr_left && (!r_fb_valid || i_fb_wr_ready);
                if (!r_addr_left && w_accept) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr    <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_gfx       <= '0;
            r_rel_x     <= '0;
            r_rel_y     <= '0;
            r_addr_left <= 1'b0;
            r_fb_valid  <= 1'b0;
            r_fb_x      <= '0;
            r_fb_y      <= '0;
            r_fb_color  <= '0;
        end else begin
            if (w_take) begin
                r_col       <= i_req_col[w_grant_idx*TILE_COL_BITS +: TILE_COL_BITS];
                r_row       <= i_req_row[w_grant_idx*TILE_ROW_BITS +: TILE_ROW_BITS];
                r_gfx       <= i_req_gfx[w_grant_idx*GFX_BITS +: GFX_BITS];
                r_rr_ptr    <= (w_grant_idx == c_PTR_W'(NUM_REQ - 1)) ? '0
                                                                      : w_grant_idx + c_PTR_W'(1);
                r_rel_x     <= '0;
                r_rel_y     <= '0;
                r_addr_left <= 1'b1;
            end
            if (w_load) begin
                r_fb_color <= i_gfx_pixels;
                r_fb_x     <= {r_col, r_rel_x};
                r_fb_y     <= {r_row, r_rel_y};
                r_fb_valid <= 1'b1;
                r_rel_x    <= r_rel_x + REL_BITS'(1);
                if (r_rel_x == c_REL_LAST) begin
                    r_rel_y <= r_rel_y + REL_BITS'(1);
                end
                if (w_last_addr) begin
                    r_addr_left <= 1'b0;
                end
            end else if (w_accept) begin
                r_fb_valid <= 1'b0;
            end
        end
    end

    assign o_gfx_sel     = r_gfx;
    assign o_rel_x       = r_rel_x;
    assign o_rel_y       = r_rel_y;
    assign o_fb_wr_valid = r_fb_valid;
    assign o_fb_x        = r_fb_x;
    assign o_fb_y        = r_fb_y;
    assign o_fb_color    = r_fb_color;
    assign o_busy        = (r_state != IDLE);
    assign o_done        = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_tile_redraw_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_tile_redraw_scheduler : directed self-checking bench for the tile blitter
// Rev 1.0
// ============================================================================
module tb_tile_redraw_scheduler;

    localparam int NR = 4;
    localparam int CB = 5;
    localparam int RB = 5;
    localparam int GB = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NR-1:0]   req_valid;
    logic [NR*CB-1:0] req_col;
    logic [NR*RB-1:0] req_row;
    logic [NR*GB-1:0] req_gfx;
    logic [NR-1:0]   req_ready;
    logic [GB-1:0]   gfx_sel;
    logic [3:0]      rel_x, rel_y;
    logic [7:0]      gfx_pixels;
    logic            fb_wr_valid, fb_wr_ready;
    logic [8:0]      fb_x, fb_y;
    logic [7:0]      fb_color;
    logic            busy, done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [8:0] wx [256];
    logic [8:0] wy [256];
    logic [7:0] wc [256];
    int         nw, t_first, t_last, t_done, stall_bad;
    logic [3:0] grant_val;
    logic       busy_at_done;

    always #5 clk = ~clk;

    // Tile ROM model: empty box is all black, other graphics are position coded.
    function automatic logic [7:0] rom(input logic [2:0] g, input logic [3:0] x, input logic [3:0] y);
        if (g == 3'd0) return 8'h00;
        return {g, 5'b0} ^ {y, x};
    endfunction

    assign gfx_pixels = rom(gfx_sel, rel_x, rel_y);

    tile_redraw_scheduler dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_req_valid   (req_valid),
        .i_req_col     (req_col),
        .i_req_row     (req_row),
        .i_req_gfx     (req_gfx),
        .o_req_ready   (req_ready),
        .o_gfx_sel     (gfx_sel),
        .o_rel_x       (rel_x),
        .o_rel_y       (rel_y),
        .i_gfx_pixels  (gfx_pixels),
        .o_fb_wr_valid (fb_wr_valid),
        .i_fb_wr_ready (fb_wr_ready),
        .o_fb_x        (fb_x),
        .o_fb_y        (fb_y),
        .o_fb_color    (fb_color),
        .o_busy        (busy),
        .o_done        (done)
    );

    // Issues one request from a drive point (1ns after posedge) and records the blit.
    // mode 0: ready always high; mode 1: ready pattern 1,0,0 repeating.
    task automatic run_tile(input int idx, input int col, input int row, input int gfx,
                            input int mode, input int abort_at);
        bit         pstall, got;
        logic [8:0] px, py;
        logic [7:0] pc;
        nw = 0; t_first = -1; t_last = -1; t_done = -1; stall_bad = 0;
        grant_val = '0; busy_at_done = 1'b0;
        pstall = 1'b0; got = 1'b0; px = '0; py = '0; pc = '0;
        for (int i = 0; i < 256; i++) begin
            wx[i] = 'x; wy[i] = 'x; wc[i] = 'x;
        end
        req_col[idx*CB +: CB] = CB'(col);
        req_row[idx*RB +: RB] = RB'(row);
        req_gfx[idx*GB +: GB] = GB'(gfx);
        req_valid[idx]        = 1'b1;
        fb_wr_ready           = 1'b1;
        for (int w = 0; w < 2000 && !got; w++) begin
            #1;
            if (req_ready != '0) begin
                got       = 1'b1;
                grant_val = req_ready;
            end else begin
                @(posedge clk); #1;
            end
        end
        if (!got) begin
            req_valid[idx] = 1'b0;
            return;
        end
        for (int t = 1; t < 1200; t++) begin
            @(posedge clk); #1;
            req_valid[idx] = 1'b0;
            fb_wr_ready    = (mode == 0) ? 1'b1 : ((t % 3) == 1);
            #1;
            if (pstall && (!fb_wr_valid || fb_x !== px || fb_y !== py || fb_color !== pc))
                stall_bad++;
            if (fb_wr_valid && t_first < 0) t_first = t;
            if (fb_wr_valid && fb_wr_ready) begin
                if (nw < 256) begin
                    wx[nw] = fb_x; wy[nw] = fb_y; wc[nw] = fb_color;
                end
                nw++;
                t_last = t;
            end
            pstall = fb_wr_valid && !fb_wr_ready;
            px = fb_x; py = fb_y; pc = fb_color;
            if (done) begin
                t_done       = t;
                busy_at_done = busy;
                break;
            end
            if (abort_at >= 0 && nw >= abort_at) break;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = '0; req_col = '0; req_row = '0; req_gfx = '0; fb_wr_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({req_ready, busy, done, fb_wr_valid} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 0000000", {req_ready, busy, done, fb_wr_valid});
        end
        n_tests++;
        if ({fb_x, fb_y, fb_color, rel_x, rel_y, gfx_sel} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got fb_x=%0d fb_y=%0d col=%h rel=%0d,%0d gfx=%0d expected all 0",
                     fb_x, fb_y, fb_color, rel_x, rel_y, gfx_sel);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (busy !== 1'b0 || req_ready !== 4'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got busy=%b ready=%b expected 0 0000", busy, req_ready);
        end
    endtask

    task automatic test_single();
        int errs;
        run_tile(2, 3, 5, 0, 0, -1);
        n_tests++;
        if (grant_val !== 4'b0100) begin
            n_fail++; $display("FAIL single_grant: got %b expected 0100", grant_val);
        end
        n_tests++;
        if (t_first != 2) begin
            n_fail++; $display("FAIL single_first_valid: got T+%0d expected T+2", t_first);
        end
        n_tests++;
        if (nw != 256 || t_last != 257) begin
            n_fail++; $display("FAIL single_count: got %0d writes last T+%0d expected 256 last T+257", nw, t_last);
        end
        n_tests++;
        if (t_done != 258 || busy_at_done !== 1'b1) begin
            n_fail++; $display("FAIL single_done: got T+%0d busy=%b expected T+258 busy=1", t_done, busy_at_done);
        end
        errs = 0;
        for (int i = 0; i < 256; i++)
            if (wx[i] !== 9'(48 + i % 16) || wy[i] !== 9'(80 + i / 16) || wc[i] !== 8'h00) errs++;
        n_tests++;
        if (errs != 0) begin
            n_fail++; $display("FAIL single_pixels: got %0d bad writes expected 0", errs);
        end
        @(posedge clk); #1;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL single_idle: got busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_backpressure();
        int errs;
        run_tile(1, 7, 2, 1, 1, -1);
        n_tests++;
        if (grant_val !== 4'b0010) begin
            n_fail++; $display("FAIL bp_grant: got %b expected 0010", grant_val);
        end
        n_tests++;
        if (nw != 256 || t_done < 0) begin
            n_fail++; $display("FAIL bp_count: got %0d writes done_t=%0d expected 256 with done", nw, t_done);
        end
        n_tests++;
        if (stall_bad != 0) begin
            n_fail++; $display("FAIL bp_stable: got %0d unstable stall cycles expected 0", stall_bad);
        end
        errs = 0;
        for (int i = 0; i < 256; i++)
            if (wx[i] !== 9'(112 + i % 16) || wy[i] !== 9'(32 + i / 16) ||
                wc[i] !== rom(3'd1, 4'(i % 16), 4'(i / 16))) errs++;
        n_tests++;
        if (errs != 0) begin
            n_fail++; $display("FAIL bp_order: got %0d bad writes expected 0", errs);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_corner();
        run_tile(0, 31, 31, 3, 0, -1);
        n_tests++;
        if (wx[0] !== 9'd496 || wy[0] !== 9'd496 || wc[0] !== rom(3'd3, 4'd0, 4'd0)) begin
            n_fail++; $display("FAIL corner_first: got (%0d,%0d) %h expected (496,496) %h",
                               wx[0], wy[0], wc[0], rom(3'd3, 4'd0, 4'd0));
        end
        n_tests++;
        if (wx[255] !== 9'd511 || wy[255] !== 9'd511 || wc[255] !== rom(3'd3, 4'd15, 4'd15)) begin
            n_fail++; $display("FAIL corner_last: got (%0d,%0d) %h expected (511,511) %h",
                               wx[255], wy[255], wc[255], rom(3'd3, 4'd15, 4'd15));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_blit();
        int done_seen;
        run_tile(3, 1, 1, 2, 0, 100);
        n_tests++;
        if (nw != 100) begin
            n_fail++; $display("FAIL abort_reach: got %0d writes expected 100", nw);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({req_ready, busy, done, fb_wr_valid} !== 7'b0 ||
            {fb_x, fb_y, fb_color, rel_x, rel_y, gfx_sel} !== '0) begin
            n_fail++; $display("FAIL abort_outputs: got busy=%b valid=%b fb=(%0d,%0d) rel=(%0d,%0d) expected all 0",
                               busy, fb_wr_valid, fb_x, fb_y, rel_x, rel_y);
        end
        done_seen = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (done !== 1'b0) done_seen++;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) done_seen++;
        end
        n_tests++;
        if (done_seen != 0) begin
            n_fail++; $display("FAIL abort_no_done: got %0d cycles with done/busy expected 0", done_seen);
        end
        run_tile(3, 1, 1, 2, 0, -1);
        n_tests++;
        if (grant_val !== 4'b1000 || t_first != 2) begin
            n_fail++; $display("FAIL restart_grant: got %b first T+%0d expected 1000 first T+2", grant_val, t_first);
        end
        n_tests++;
        if (wx[0] !== 9'd16 || wy[0] !== 9'd16 || nw != 256) begin
            n_fail++; $display("FAIL restart_origin: got (%0d,%0d) %0d writes expected (16,16) 256 writes",
                               wx[0], wy[0], nw);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_round_robin();
        int order [4];
        int gt [4];
        int ng, onehot_bad, waited;
        ng = 0; onehot_bad = 0;
        for (int i = 0; i < 4; i++) begin order[i] = -1; gt[i] = 0; end
        req_col = '0; req_row = '0; req_gfx = '0;
        req_col[3*CB +: CB] = 5'd10;
        req_row[3*RB +: RB] = 5'd4;
        req_gfx[3*GB +: GB] = 3'd2;
        fb_wr_ready = 1'b1;
        req_valid = 4'b1001;
        for (int t = 0; t < 2000 && ng < 4; t++) begin
            #1;
            if (req_ready != '0) begin
                if ($countones(req_ready) != 1) onehot_bad++;
                order[ng] = req_ready[0] ? 0 : (req_ready[3] ? 3 : 9);
                gt[ng]    = t;
                ng++;
            end
            @(posedge clk); #1;
        end
        req_valid = '0;
        n_tests++;
        if (order[0] != 0 || order[1] != 3 || order[2] != 0 || order[3] != 3) begin
            n_fail++; $display("FAIL rr_order: got %0d,%0d,%0d,%0d expected 0,3,0,3",
                               order[0], order[1], order[2], order[3]);
        end
        n_tests++;
        if (onehot_bad != 0) begin
            n_fail++; $display("FAIL rr_onehot: got %0d non-one-hot grants expected 0", onehot_bad);
        end
        n_tests++;
        if (gt[1] - gt[0] != 259 || gt[2] - gt[1] != 259 || gt[3] - gt[2] != 259) begin
            n_fail++; $display("FAIL rr_spacing: got %0d,%0d,%0d expected 259,259,259",
                               gt[1] - gt[0], gt[2] - gt[1], gt[3] - gt[2]);
        end
        waited = 0;
        while (busy && waited < 400) begin
            @(posedge clk); #1;
            waited++;
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL rr_drain: got busy=%b after %0d cycles expected 0", busy, waited);
        end
    endtask

    task automatic test_back_to_back();
        int waited;
        bit seen;
        run_tile(1, 4, 6, 2, 0, -1);
        n_tests++;
        if (t_done != 258) begin
            n_fail++; $display("FAIL b2b_first_done: got T+%0d expected T+258", t_done);
        end
        req_col[2*CB +: CB] = 5'd9;
        req_row[2*RB +: RB] = 5'd9;
        req_gfx[2*GB +: GB] = 3'd1;
        req_valid[2]        = 1'b1;
        #1;
        n_tests++;
        if (req_ready !== 4'b0000 || busy !== 1'b1) begin
            n_fail++; $display("FAIL b2b_in_done: got ready=%b busy=%b expected 0000 1", req_ready, busy);
        end
        @(posedge clk); #1;
        n_tests++;
        if (req_ready !== 4'b0100 || busy !== 1'b0) begin
            n_fail++; $display("FAIL b2b_idle_grant: got ready=%b busy=%b expected 0100 0", req_ready, busy);
        end
        @(posedge clk); #1;
        req_valid = '0;
        #1;
        n_tests++;
        if (busy !== 1'b1 || req_ready !== 4'b0000) begin
            n_fail++; $display("FAIL b2b_busy_again: got busy=%b ready=%b expected 1 0000", busy, req_ready);
        end
        seen = 1'b0;
        waited = 0;
        while (!seen && waited < 400) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
            waited++;
        end
        n_tests++;
        if (!seen) begin
            n_fail++; $display("FAIL b2b_second_done: got no done in %0d cycles expected done", waited);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_corner();
        test_reset_mid_blit();
        test_round_robin();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
